dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder side of the core's MEM-stage data-memory interface. It accepts one load or store request at a time from the pipeline (MemRead/MemWrite, byte address, store data) and returns load data with a one-cycle `ready` pulse after a programmable number of wait states. It holds the word-organised data RAM and replaces the zero-latency memory wherever the pipeline must tolerate multi-cycle memory. While `busy` is high, the pipeline stall logic freezes the MEM stage.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of two, 2..65536.
- `WAIT_CYCLES`, default 2: wait states between request capture and response, 0..15.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `MemRead`  in  1: load request. Sampled only in IDLE.
- `MemWrite`  in  1: store request. Sampled only in IDLE.
- `address`  in  32: byte address. Sampled with the request.
- `write_data`  in  32: store data. Sampled with the request.
- `read_data`  out  32: load result. Updated only by a successful load.
- `ready`  out  1: one-cycle completion pulse for every accepted request.
- `busy`  out  1: high whenever state is not IDLE.
- `error`  out  1: high only alongside `ready`, for a rejected request.

## Operation

- **FSM states:** IDLE, WAIT, RESP. State is held in registers. `busy` = (state != IDLE).
- **IDLE:** at an edge where `MemRead | MemWrite` = 1, capture op, `address` and `write_data` into internal registers.
  - Load wait counter = `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, otherwise RESP.
- **WAIT:** counter decrements each edge. At the edge where the counter equals 1, go to RESP. All request inputs are ignored.
- **RESP:** `ready` = 1 for exactly this cycle. Next state is IDLE unconditionally. All request inputs are ignored.
- **Rejection:** a captured request is rejected when any of these hold:
  - `address[1:0]` != 0 (misaligned);
  - word index `address[31:2]` >= `DEPTH_WORDS` (out of range);
  - `MemRead` and `MemWrite` are both 1.
- **Rejected request:** `error` = 1 during RESP, no RAM write, `read_data` unchanged.
- **Accepted store:** RAM[`address[31:2]`] is written with the captured data at the edge that ends RESP. `read_data` is unchanged.
- **Accepted load:** `read_data` is loaded from RAM[`address[31:2]`] at the edge entering RESP. It is valid while `ready` = 1 and held until the next accepted load.
- **Request handshake:**
  - The requester holds its request until it sees `ready`, then drops it in the following cycle.
  - A request still asserted in the IDLE cycle after RESP is treated as a new request.
- **RAM:** contents are not cleared by `reset`. They initialise to zero at simulation start.
- **Reset:**
  - Outputs: `read_data` = 0, `ready` = 0, `busy` = 0, `error` = 0. State goes to IDLE and the counter to 0.
  - Mid-operation reset (WAIT or RESP) aborts the transaction. A store whose RESP edge coincides with `reset` = 1 is NOT written. No `ready` is issued for the aborted request.

## Timing

- A request sampled at edge N gives `ready` high in cycle N+1+`WAIT_CYCLES`, i.e. between edges N+1+W and N+2+W.
- Store data is visible in RAM after edge N+2+W.
- Minimum spacing between request-capture edges is 2+`WAIT_CYCLES` cycles: capture, W waits, RESP, then back in IDLE.
- Throughput is one transaction per 2+W cycles with back-to-back requests.
- Input changes during WAIT or RESP have no effect on the transaction in flight.
- `error` and `ready` rise and fall on the same edges.
- No combinational path from any input to any output. All outputs are registered.

## Test plan

- **Store then load, W=2.** Store 0xDEADBEEF to 0x00000010 at edge 0 → `ready` in cycle 3, `busy` high in cycles 1–3. Load 0x10 at edge 4 → `ready` in cycle 7 with `read_data` = 0xDEADBEEF and `error` = 0.
- **Zero wait states, W=0.** Load of an address previously stored with 0x12345678 → `ready` and `read_data` = 0x12345678 in the cycle right after capture. Back-to-back loads capture every 2nd edge.
- **Rejections.**
  - Store to 0x00000013 → `ready` and `error` together, RAM unchanged.
  - Load from 0x00001000 with `DEPTH_WORDS` = 1024 → `error` = 1, `read_data` keeps its prior value.
  - `MemRead` = `MemWrite` = 1 → `error` = 1, no write.
- **Reset mid-operation.** Store 0xCAFEF00D to 0x20 (old value 0x11111111), then assert `reset` during WAIT → all outputs 0, no `ready` pulse. A subsequent load of 0x20 returns 0x11111111.
- **Reset on the RESP edge.** A store with `reset` = 1 at its RESP-ending edge is not written. A read-back of that address returns the old value.
- **Input isolation.** Capture a load of 0x10. During WAIT, toggle `address` to 0x14, set `MemWrite` = 1 and change `write_data` → response carries RAM[4] data, RAM[5] is untouched, and exactly one `ready` pulse is issued.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, a fixed
// number of wait states, then a one-cycle ready pulse (with error on rejects).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  // state  | meaning
  // S_IDLE | waiting for MemRead/MemWrite, captures the request
  // S_WAIT | counting wait states, request inputs ignored
  // S_RESP | ready (and error on reject) high for this one cycle

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_rd;
  logic            r_wr;
  logic            r_reject;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_read_data;
  logic            r_ready;
  logic            r_busy;
  logic            r_error;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_reject_in;
  logic [AW-1:0]   w_in_idx;
  logic            w_ld_fire;
  logic [AW-1:0]   w_ld_idx;
  logic            w_st_fire;
  logic            w_resp_err;

  assign w_req       = MemRead | MemWrite;
  assign w_reject_in = (address[1:0] != 2'b00) ||
                       (address[31:2] >= 30'(DEPTH_WORDS)) ||
                       (MemRead && MemWrite);
  assign w_in_idx    = address[AW+1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the load reads straight from the live request inputs.
  always_comb begin
    w_ld_fire  = 1'b0;
    w_ld_idx   = r_idx;
    w_resp_err = r_reject;
    w_st_fire  = (r_state == S_RESP) && r_wr && !r_reject;
    if (r_state == S_IDLE) begin
      w_ld_idx   = w_in_idx;
      w_resp_err = w_reject_in;
      w_ld_fire  = (w_state_nxt == S_RESP) && MemRead && !w_reject_in;
    end else if (r_state == S_WAIT) begin
      w_ld_fire  = (w_state_nxt == S_RESP) && r_rd && !r_reject;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_reject    <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_read_data <= 32'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_RESP);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_error <= (w_state_nxt == S_RESP) && w_resp_err;
      if (r_state == S_IDLE && w_req) begin
        r_rd     <= MemRead;
        r_wr     <= MemWrite;
        r_reject <= w_reject_in;
        r_idx    <= w_in_idx;
        r_wdata  <= write_data;
        r_cnt    <= WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_ld_fire) begin
        r_read_data <= r_mem[w_ld_idx];
      end
    end
  end

  // RAM is never cleared; a reset on the RESP edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && w_st_fire) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign read_data = r_read_data;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign error     = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a W=2 instance (index 0) and a W=0 instance
// (index 1), both checked against a word-array memory model.
module tb_dmem_responder;

  logic        clk;
  logic        rst [2];
  logic        mr  [2];
  logic        mw  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] rdat[2];
  logic        rdy [2];
  logic        bsy [2];
  logic        er  [2];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] rd_model [2];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
    .address(ad[0]), .write_data(wd[0]), .read_data(rdat[0]),
    .ready(rdy[0]), .busy(bsy[0]), .error(er[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
    .address(ad[1]), .write_data(wd[1]), .read_data(rdat[1]),
    .ready(rdy[1]), .busy(bsy[1]), .error(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit is_bad(bit rd, bit wr, logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024) || (rd && wr);
  endfunction

  // One full request/response exchange on DUT d, checked against the model.
  task automatic do_txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wdat, input bit perturb);
    bit bad;
    bit seen;
    int lat;
    int idx;
    logic [31:0] exp_rd;
    bad    = is_bad(rd, wr, a);
    idx    = bad ? 0 : int'(a[11:2]);
    exp_rd = (!bad && rd) ? mdl[d][idx] : rd_model[d];
    @(negedge clk);
    mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = wdat;
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rdy[d]) seen = 1;
      else begin
        n_vec++;
        if (bsy[d] !== 1'b1) begin
          n_err++;
          $display("FAIL busy_wait dut%0d addr=%h: busy=%b required 1", d, a, bsy[d]);
        end
        if (perturb) begin
          ad[d] = a + 32'd4; mw[d] = 1'b1; wd[d] = $urandom;
        end
      end
    end
    n_vec++;
    if (!seen || lat != wait_of(d) + 1) begin
      n_err++;
      $display("FAIL latency dut%0d addr=%h: ready after %0d cycles (seen=%0b) required %0d",
               d, a, lat, seen, wait_of(d) + 1);
    end
    n_vec++;
    if (er[d] !== bad) begin
      n_err++;
      $display("FAIL error_flag dut%0d addr=%h rd=%0b wr=%0b: error=%b required %b",
               d, a, rd, wr, er[d], bad);
    end
    n_vec++;
    if (rdat[d] !== exp_rd) begin
      n_err++;
      $display("FAIL read_data dut%0d addr=%h: got %h required %h", d, a, rdat[d], exp_rd);
    end
    n_vec++;
    if (bsy[d] !== 1'b1) begin
      n_err++;
      $display("FAIL busy_resp dut%0d addr=%h: busy=%b required 1", d, a, bsy[d]);
    end
    mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
    if (!bad) begin
      if (rd) rd_model[d] = mdl[d][idx];
      if (wr) mdl[d][idx] = wdat;
    end
    @(negedge clk);
    n_vec++;
    if (rdy[d] !== 1'b0 || bsy[d] !== 1'b0 || er[d] !== 1'b0) begin
      n_err++;
      $display("FAIL after_resp dut%0d: ready=%b busy=%b error=%b required 0 0 0",
               d, rdy[d], bsy[d], er[d]);
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdat[d] !== 32'd0 || rdy[d] !== 1'b0 || bsy[d] !== 1'b0 || er[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: rd=%h ready=%b busy=%b error=%b required all 0",
                 d, rdat[d], rdy[d], bsy[d], er[d]);
      end
      rd_model[d] = 32'd0;
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  task automatic test_preload();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        do_txn(d, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
  endtask

  task automatic test_store_load();
    do_txn(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
  endtask

  task automatic test_zero_wait();
    do_txn(1, 1'b0, 1'b1, 32'h0000_0028, 32'h1234_5678, 1'b0);
    do_txn(1, 1'b1, 1'b0, 32'h0000_0028, 32'd0, 1'b0);
  endtask

  // Request held high continuously: W=0 must capture every second edge.
  task automatic test_back_to_back();
    int j;
    j = 0;
    @(negedge clk);
    mr[1] = 1'b1; ad[1] = 32'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (rdy[1] !== 1'(k % 2)) begin
        n_err++;
        $display("FAIL b2b_ready step %0d: ready=%b required %0d", k, rdy[1], k % 2);
      end
      if (k % 2 == 1) begin
        n_vec++;
        if (rdat[1] !== mdl[1][j]) begin
          n_err++;
          $display("FAIL b2b_data word %0d: got %h required %h", j, rdat[1], mdl[1][j]);
        end
        rd_model[1] = mdl[1][j];
        j++;
        if (j < 6) ad[1] = 32'(j * 4);
        else mr[1] = 1'b0;
      end
    end
    ad[1] = 32'd0;
  endtask

  task automatic test_rejections();
    do_txn(0, 1'b0, 1'b1, 32'h0000_0013, 32'hBAD0_0001, 1'b0);
    do_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 1'b0);
    do_txn(0, 1'b1, 1'b1, 32'h0000_0018, 32'hBAD0_0002, 1'b0);
    do_txn(0, 1'b1, 1'b0, 32'h0000_0018, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_txn(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0);
    @(negedge clk);
    mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = 32'h0000_0020; wd[0] = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b1; mw[0] = 1'b0; ad[0] = 32'd0; wd[0] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (rdat[0] !== 32'd0 || rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || er[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: rd=%h ready=%b busy=%b error=%b required all 0",
               rdat[0], rdy[0], bsy[0], er[0]);
    end
    rst[0] = 1'b0;
    rd_model[0] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (rdy[0] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_no_ready cycle %0d: ready=%b required 0", k, rdy[0]);
      end
    end
    do_txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b0);
  endtask

  task automatic test_reset_resp();
    bit seen;
    do_txn(0, 1'b0, 1'b1, 32'h0000_0024, 32'h2222_2222, 1'b0);
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 32'h0000_0024; wd[0] = 32'h3333_3333;
    @(posedge clk);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rdy[0]) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_resp_ready: ready=0 required 1 within 10 cycles");
    end
    rst[0] = 1'b1; mw[0] = 1'b0; ad[0] = 32'd0; wd[0] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rd_model[0] = 32'd0;
    n_vec++;
    if (rdat[0] !== 32'd0 || rdy[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_resp_outputs: rd=%h ready=%b busy=%b required 0 0 0",
               rdat[0], rdy[0], bsy[0]);
    end
    do_txn(0, 1'b1, 1'b0, 32'h0000_0024, 32'd0, 1'b0);
  endtask

  task automatic test_isolation();
    do_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    do_txn(0, 1'b1, 1'b0, 32'h0000_0014, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    int d;
    int r;
    int k;
    bit rd;
    bit wr;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      d = i % 2;
      r = $urandom_range(0, 9);
      rd = (r < 4) || (r >= 8);
      wr = (r >= 4);
      k = $urandom_range(0, 9);
      if (k < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (k == 7) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(1024, 32'h3FFF_FFFF)) << 2;
      do_txn(d, rd, wr, a, $urandom, 1'b0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
      rd_model[d] = 32'd0;
    end
    test_reset();
    test_preload();
    test_store_load();
    test_zero_wait();
    test_back_to_back();
    test_rejections();
    test_reset_mid();
    test_reset_resp();
    test_isolation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
